// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared types for the multi-channel watchdog
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    TIMEOUT = 2'b10
  } wdt_state_e;

endpackage

// File: rtl/wdt_channel.sv
// rtl/wdt_channel.sv - one watchdog channel: shadowed config, countdown FSM, warn/wto/early flags
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             kick,
  input  logic             clr,
  input  logic             win_mode,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_warn,
  output logic [CNT_W-1:0] cnt,
  output logic             warn,
  output logic             wto,
  output logic             early
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [CNT_W-1:0] warn_thr_q, warn_thr_d;
  logic             warn_q, warn_d;
  logic             early_q, early_d;

  always_comb begin
    // Shadow next values double as the effective config, so a write lands write-through.
    timeout_d  = cfg_we ? cfg_timeout : timeout_q;
    window_d   = cfg_we ? cfg_window  : window_q;
    warn_thr_d = cfg_we ? cfg_warn    : warn_thr_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    early_d    = early_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      early_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = timeout_d;
        end
        RUN: begin
          if (kick) begin
            if (win_mode && (cnt_q > window_d)) begin
              state_d = TIMEOUT;
              early_d = 1'b1;
            end else begin
              cnt_d = timeout_d;
            end
          end else if (tick) begin
            if (cnt_q == '0) state_d = TIMEOUT;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        TIMEOUT: begin
          if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            early_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          early_d = 1'b0;
        end
      endcase
    end
    warn_d = (state_d == RUN) && (cnt_d <= warn_thr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      timeout_q  <= '0;
      window_q   <= '0;
      warn_thr_q <= '0;
      warn_q     <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      window_q   <= window_d;
      warn_thr_q <= warn_thr_d;
      warn_q     <= warn_d;
      early_q    <= early_d;
    end
  end

  assign cnt   = cnt_q;
  assign warn  = warn_q;
  assign wto   = (state_q == TIMEOUT);
  assign early = early_q;

endmodule

// File: rtl/wdt_multi.sv
// rtl/wdt_multi.sv - shared tick prescaler driving NUM_CH independent watchdog channels
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRE_W-1:0]        tick_div,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       kick,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       win_mode,
  input  logic [NUM_CH-1:0]       cfg_we,
  input  logic [CNT_W-1:0]        cfg_timeout,
  input  logic [CNT_W-1:0]        cfg_window,
  input  logic [CNT_W-1:0]        cfg_warn,
  output logic [NUM_CH*CNT_W-1:0] cnt,
  output logic [NUM_CH-1:0]       warn,
  output logic [NUM_CH-1:0]       wto,
  output logic [NUM_CH-1:0]       early,
  output logic                    wto_any
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick;

  always_comb begin
    tick      = (pre_cnt_q == tick_div);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_cnt_q <= '0;
    else      pre_cnt_q <= pre_cnt_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdt_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .en          (en[i]),
      .kick        (kick[i]),
      .clr         (clr[i]),
      .win_mode    (win_mode[i]),
      .cfg_we      (cfg_we[i]),
      .cfg_timeout (cfg_timeout),
      .cfg_window  (cfg_window),
      .cfg_warn    (cfg_warn),
      .cnt         (cnt[i*CNT_W +: CNT_W]),
      .warn        (warn[i]),
      .wto         (wto[i]),
      .early       (early[i])
    );
  end

  assign wto_any = |wto;

endmodule

// File: tb/tb_wdt_multi.sv
// tb/tb_wdt_multi.sv - directed self-checking bench for wdt_multi
module tb_wdt_multi;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  tick_div = '0;
  logic [3:0]   en = '0, kick = '0, clr = '0, win_mode = '0, cfg_we = '0;
  logic [31:0]  cfg_timeout = '0, cfg_window = '0, cfg_warn = '0;
  logic [127:0] cnt;
  logic [3:0]   warn, wto, early;
  logic         wto_any;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt;

  wdt_multi dut (
    .clk(clk), .rst(rst), .tick_div(tick_div), .en(en), .kick(kick), .clr(clr),
    .win_mode(win_mode), .cfg_we(cfg_we), .cfg_timeout(cfg_timeout),
    .cfg_window(cfg_window), .cfg_warn(cfg_warn), .cnt(cnt), .warn(warn),
    .wto(wto), .early(early), .wto_any(wto_any)
  );

  always #5 clk = ~clk;

  // Edges since reset release; with a fixed tick_div the next edge ticks when ecnt % (div+1) == div.
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  function automatic logic [31:0] cnt_ch(input int i);
    return cnt[i*32 +: 32];
  endfunction

  task automatic do_reset(input logic [15:0] d);
    rst = 1'b0;
    en = '0; kick = '0; clr = '0; win_mode = '0; cfg_we = '0;
    cfg_timeout = '0; cfg_window = '0; cfg_warn = '0;
    tick_div = d;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(16'd0);
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %h want 0", cnt); end
    n_cmp++; if (warn !== 4'b0) begin n_err++; $display("FAIL reset_warn got %b want 0000", warn); end
    n_cmp++; if (wto !== 4'b0) begin n_err++; $display("FAIL reset_wto got %b want 0000", wto); end
    n_cmp++; if (early !== 4'b0) begin n_err++; $display("FAIL reset_early got %b want 0000", early); end
    n_cmp++; if (wto_any !== 1'b0) begin n_err++; $display("FAIL reset_wto_any got %b want 0", wto_any); end
  endtask

  task automatic test_basic_timeout();
    do_reset(16'd0);
    cfg_timeout = 32'd5; cfg_we = 4'b0001; en = 4'b0001;
    @(negedge clk);
    cfg_we = '0;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (cnt_ch(0) !== 32'(5 - k)) begin n_err++; $display("FAIL basic_cnt step %0d got %0d want %0d", k, cnt_ch(0), 5 - k); end
      n_cmp++; if (wto[0] !== 1'b0) begin n_err++; $display("FAIL basic_early_wto step %0d got %b want 0", k, wto[0]); end
      @(negedge clk);
    end
    n_cmp++; if (wto[0] !== 1'b1) begin n_err++; $display("FAIL basic_wto got %b want 1", wto[0]); end
    n_cmp++; if (wto_any !== 1'b1) begin n_err++; $display("FAIL basic_wto_any got %b want 1", wto_any); end
    n_cmp++; if (wto[3:1] !== 3'b000) begin n_err++; $display("FAIL basic_other_wto got %b want 000", wto[3:1]); end
    n_cmp++; if (cnt_ch(0) !== 32'd0) begin n_err++; $display("FAIL basic_nowrap got %0d want 0", cnt_ch(0)); end
  endtask

  task automatic test_kick_priority();
    int guard;
    int wto_seen;
    do_reset(16'd3);
    cfg_timeout = 32'd10; cfg_we = 4'b0001; en = 4'b0001;
    @(negedge clk);
    cfg_we = '0;
    guard = 0;
    while (!(cnt_ch(0) == 32'd2 && (ecnt % 4) == 3) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++; if (guard >= 200) begin n_err++; $display("FAIL kick_wait got timeout want cnt=2 on tick"); end
    kick = 4'b0001;
    @(negedge clk);
    kick = '0;
    n_cmp++; if (cnt_ch(0) !== 32'd10) begin n_err++; $display("FAIL kick_beats_tick got %0d want 10", cnt_ch(0)); end
    wto_seen = 0;
    for (int c = 1; c <= 90; c++) begin
      if (c % 30 == 0) kick = 4'b0001;
      @(negedge clk);
      kick = '0;
      if (wto[0]) wto_seen++;
    end
    n_cmp++; if (wto_seen !== 0) begin n_err++; $display("FAIL kick_keepalive got %0d wto cycles want 0", wto_seen); end
    guard = 0;
    while (!wto[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++; if (wto[0] !== 1'b1) begin n_err++; $display("FAIL kick_starve got wto=%b want 1", wto[0]); end
  endtask

  task automatic test_window();
    int guard;
    do_reset(16'd0);
    win_mode = 4'b0010;
    cfg_timeout = 32'd20; cfg_window = 32'd8; cfg_we = 4'b0010; en = 4'b0010;
    @(negedge clk);
    cfg_we = '0;
    guard = 0;
    while (cnt_ch(1) != 32'd12 && guard < 50) begin @(negedge clk); guard++; end
    n_cmp++; if (guard >= 50) begin n_err++; $display("FAIL win_wait12 got timeout want cnt=12"); end
    kick = 4'b0010;
    @(negedge clk);
    kick = '0;
    n_cmp++; if (early[1] !== 1'b1) begin n_err++; $display("FAIL win_early got %b want 1", early[1]); end
    n_cmp++; if (wto[1] !== 1'b1) begin n_err++; $display("FAIL win_wto got %b want 1", wto[1]); end
    en = 4'b0000;
    @(negedge clk);
    n_cmp++; if (early[1] !== 1'b0) begin n_err++; $display("FAIL win_dis_early got %b want 0", early[1]); end
    en = 4'b0010;
    @(negedge clk);
    n_cmp++; if (cnt_ch(1) !== 32'd20) begin n_err++; $display("FAIL win_restart got %0d want 20", cnt_ch(1)); end
    guard = 0;
    while (cnt_ch(1) != 32'd8 && guard < 50) begin @(negedge clk); guard++; end
    kick = 4'b0010;
    @(negedge clk);
    kick = '0;
    n_cmp++; if (cnt_ch(1) !== 32'd20) begin n_err++; $display("FAIL win_legal_reload got %0d want 20", cnt_ch(1)); end
    n_cmp++; if ({early[1], wto[1]} !== 2'b00) begin n_err++; $display("FAIL win_legal_flags got %b want 00", {early[1], wto[1]}); end
  endtask

  task automatic test_warn_clear_shadow();
    int guard;
    do_reset(16'd0);
    cfg_timeout = 32'd10; cfg_warn = 32'd3; cfg_we = 4'b0001; en = 4'b0001;
    @(negedge clk);
    cfg_we = '0;
    n_cmp++; if ({cnt_ch(0), warn[0]} !== {32'd10, 1'b0}) begin n_err++; $display("FAIL warn_start got %0d/%b want 10/0", cnt_ch(0), warn[0]); end
    guard = 0;
    while (cnt_ch(0) != 32'd4 && guard < 20) begin @(negedge clk); guard++; end
    n_cmp++; if (warn[0] !== 1'b0) begin n_err++; $display("FAIL warn_at4 got %b want 0", warn[0]); end
    @(negedge clk);
    n_cmp++; if ({cnt_ch(0), warn[0]} !== {32'd3, 1'b1}) begin n_err++; $display("FAIL warn_at3 got %0d/%b want 3/1", cnt_ch(0), warn[0]); end
    @(negedge clk);
    kick = 4'b0001;
    @(negedge clk);
    kick = '0;
    n_cmp++; if ({cnt_ch(0), warn[0]} !== {32'd10, 1'b0}) begin n_err++; $display("FAIL warn_kick got %0d/%b want 10/0", cnt_ch(0), warn[0]); end
    repeat (10) @(negedge clk);
    n_cmp++; if ({cnt_ch(0), warn[0], wto[0]} !== {32'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL warn_at0 got %0d/%b/%b want 0/1/0", cnt_ch(0), warn[0], wto[0]); end
    @(negedge clk);
    n_cmp++; if ({warn[0], wto[0]} !== 2'b01) begin n_err++; $display("FAIL warn_timeout got %b want 01", {warn[0], wto[0]}); end
    kick = 4'b0001;
    @(negedge clk);
    kick = '0;
    n_cmp++; if ({cnt_ch(0), wto[0]} !== {32'd0, 1'b1}) begin n_err++; $display("FAIL to_kick_ignored got %0d/%b want 0/1", cnt_ch(0), wto[0]); end
    clr = 4'b0001;
    @(negedge clk);
    clr = '0;
    n_cmp++; if ({cnt_ch(0), wto[0]} !== {32'd0, 1'b0}) begin n_err++; $display("FAIL clr_idle got %0d/%b want 0/0", cnt_ch(0), wto[0]); end
    @(negedge clk);
    n_cmp++; if (cnt_ch(0) !== 32'd10) begin n_err++; $display("FAIL clr_rerun got %0d want 10", cnt_ch(0)); end
    cfg_timeout = 32'd7; cfg_we = 4'b0001;
    @(negedge clk);
    cfg_we = '0;
    n_cmp++; if (cnt_ch(0) !== 32'd9) begin n_err++; $display("FAIL shadow_hold got %0d want 9", cnt_ch(0)); end
    kick = 4'b0001;
    @(negedge clk);
    kick = '0;
    n_cmp++; if (cnt_ch(0) !== 32'd7) begin n_err++; $display("FAIL shadow_load got %0d want 7", cnt_ch(0)); end
    repeat (4) @(negedge clk);
    n_cmp++; if ({cnt_ch(0), warn[0]} !== {32'd3, 1'b1}) begin n_err++; $display("FAIL prerst_warn got %0d/%b want 3/1", cnt_ch(0), warn[0]); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({cnt, warn, wto, early, wto_any} !== '0) begin n_err++; $display("FAIL async_rst got cnt=%h w=%b t=%b e=%b a=%b want 0", cnt, warn, wto, early, wto_any); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_disable();
    do_reset(16'd0);
    cfg_timeout = 32'd0; cfg_we = 4'b0100; en = 4'b0100;
    @(negedge clk);
    cfg_we = '0;
    n_cmp++; if ({cnt_ch(2), wto[2]} !== {32'd0, 1'b0}) begin n_err++; $display("FAIL t0_run got %0d/%b want 0/0", cnt_ch(2), wto[2]); end
    @(negedge clk);
    n_cmp++; if (wto[2] !== 1'b1) begin n_err++; $display("FAIL t0_timeout got %b want 1", wto[2]); end
    @(negedge clk);
    n_cmp++; if ({cnt_ch(2), wto[2]} !== {32'd0, 1'b1}) begin n_err++; $display("FAIL t0_hold got %0d/%b want 0/1", cnt_ch(2), wto[2]); end
    en = '0;
    @(negedge clk);
    n_cmp++; if ({cnt_ch(2), wto[2], wto_any} !== {32'd0, 2'b00}) begin n_err++; $display("FAIL dis_idle got %0d/%b/%b want 0/0/0", cnt_ch(2), wto[2], wto_any); end
  endtask

  initial begin
    test_reset();
    test_basic_timeout();
    test_kick_priority();
    test_window();
    test_warn_clear_shadow();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got hang want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
